// File: rtl/simple_frame_fifo_if.sv
// Valid/ready sample stream carrying an opaque payload plus a first-of-frame marker.
interface simple_frame_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             fst;
    logic             vld;
    logic             rdy;

    modport master (output data, output fst, output vld, input rdy);
    modport slave  (input data, input fst, input vld, output rdy);
endinterface

// File: rtl/simple_frame_fifo.sv
// Frame-gated FIFO: a frame becomes visible downstream only once all FRAME_LEN samples
// are buffered; out_fst is regenerated locally and upstream framing slips are flagged.
module simple_frame_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    simple_frame_fifo_if.slave     in_if,
    simple_frame_fifo_if.master    out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done,
    output logic                   fst_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > DEPTH) begin : g_frame_chk
        $error("FRAME_LEN must be in 1..DEPTH");
    end

    typedef struct packed {
        logic             fst;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, frames;
    logic [FW-1:0] wr_cnt, rd_cnt;
    logic          wr_en, rd_en, wr_first, wr_last, rd_last;

    assign wr_first   = (wr_cnt == '0);
    assign wr_last    = (wr_cnt == F_LAST);
    assign rd_last    = (rd_cnt == F_LAST);
    assign in_if.rdy  = (cnt != FULL);
    assign out_if.vld = (frames != '0);
    assign wr_en      = in_if.vld && in_if.rdy && !clr;
    assign rd_en      = out_if.vld && out_if.rdy && !clr;
    assign frame_done = rd_en && rd_last;
    assign level      = cnt;
    // Stored entries are never reset, so gate the marker to keep X out of downstream control.
    assign out_if.data = mem[rp].data;
    assign out_if.fst  = out_if.vld && mem[rp].fst;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= '{fst: wr_first, data: in_if.data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            frames  <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            fst_err <= 1'b0;
        end else if (clr) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            frames  <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            fst_err <= 1'b0;
        end else begin
            if (wr_en) begin
                wp     <= wp + 1'b1;
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                // Framing follows the local counter only; a misplaced in_fst just raises the flag.
                if (in_if.fst != wr_first) fst_err <= 1'b1;
            end
            if (rd_en) begin
                rp     <= rp + 1'b1;
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({wr_en && wr_last, frame_done})
                2'b10:   frames <= frames + 1'b1;
                2'b01:   frames <= frames - 1'b1;
                default: frames <= frames;
            endcase
        end
    end
endmodule

// File: doc/simple_frame_fifo.md
Name: simple_frame_fifo

Overview:
- Frame-gated input buffer that sits directly upstream of simple_st0's stage_0_data input. It takes the st_data stream (float_24_8, handled as opaque bits).
- Frames are fixed-length and fst-delimited. The block releases a frame to the stage only once all FRAME_LEN samples are buffered, so a stalled source never starves the stage mid-frame.
- It regenerates out_fst from its own frame counter and flags upstream framing errors.

Parameters:
- WIDTH, 32: payload width (float_24_8 packed).
- DEPTH, 16: entries. Power of 2, at least 2.
- FRAME_LEN, 4: samples per frame. Range 1 to DEPTH; elaboration-time check.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active high.
- in_data  in  WIDTH  sample from upstream (st_data).
- in_fst  in  1  first-of-frame marker from upstream.
- in_vld  in  1  upstream valid.
- in_rdy  out  1  upstream ready.
- out_data  out  WIDTH  sample to stage_0_data.
- out_fst  out  1  regenerated first-of-frame to stage_0_data_fst.
- out_vld  out  1  to stage_0_data_vld.
- out_rdy  in  1  from stage_0_data_rdy.
- level  out  $clog2(DEPTH)+1  entries held.
- frame_done  out  1  one-cycle pulse when the last sample of a frame is read.
- fst_err  out  1  sticky upstream framing error.

Behaviour:
- Storage and pointers:
  - Flop array mem[DEPTH]; each entry is {fst, data}.
  - Write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy count cnt, 0..DEPTH.
- Reset (reset low, async): wp=rp=0, cnt=0, wr_cnt=rd_cnt=0, frames_avail=0, fst_err=0. Resulting outputs: in_rdy=1, out_vld=0, out_fst=0, level=0, frame_done=0. mem contents are not reset. out_data is don't-care but must not be X-propagated into control.
- Handshakes:
  - Write when in_vld && in_rdy. Read when out_vld && out_rdy.
  - in_rdy = (cnt != DEPTH), combinational from state only.
  - out_vld = (frames_avail != 0) and is independent of out_rdy.
  - out_data = mem[rp].data and out_fst = mem[rp].fst, both combinational read.
- Write side:
  - wr_cnt counts 0..FRAME_LEN-1.
  - Stored fst = (wr_cnt==0); in_fst is not stored.
  - If in_fst != (wr_cnt==0) on a write, set fst_err on the next edge. It stays set until reset or clr.
  - Framing is never resynchronised to in_fst.
  - wr_cnt wraps to 0 after FRAME_LEN-1. That same write is the frame-complete write.
- Read side:
  - rd_cnt counts 0..FRAME_LEN-1.
  - The read at rd_cnt==FRAME_LEN-1 is the frame-last read: frame_done=1 that cycle (combinational, qualified by the handshake), and rd_cnt wraps.
- frames_avail, 0..DEPTH/FRAME_LEN:
  - +1 on a frame-complete write.
  - -1 on a frame-last read.
  - Both in the same cycle: unchanged.
- Latency:
  - A frame-complete write at edge t gives out_vld=1 after edge t. Minimum write-to-read latency is 1 cycle.
  - No bypass path: an empty FIFO never presents in_data on out_data in the same cycle.
- Throughput: one write and one read per cycle, simultaneously.
  - Full: a simultaneous read and write is not possible, because in_rdy=0 when full; the read frees a slot for the next cycle.
  - Empty: out_vld=0.
- Partial frame: samples of an incomplete frame are held, invisible to the output, and occupy capacity. If FRAME_LEN does not divide DEPTH, a partial frame can fill the remainder. Upstream then stalls until a frame is read.
- Wrap-around: pointers wrap silently. cnt distinguishes full from empty.
- level = cnt, updated on each edge: +1 on write, -1 on read, unchanged on both.
- clr (sync, priority over all handshakes that cycle): state returns to reset values including fst_err. Writes and reads in that cycle are discarded. frame_done is forced to 0.
- Reset mid-frame: all buffered samples, including any partial frame, are lost. The next write is treated as frame start.

Test Plan:
- FRAME_LEN=4, DEPTH=16. Write samples 0x3F800000..0x3F800003 back-to-back with in_fst=1,0,0,0 and out_rdy=1 -> out_vld rises the cycle after the 4th write. Output is 4 samples in order, out_fst=1,0,0,0, frame_done on the 4th read, level returns to 0.
- Write 3 samples, then hold in_vld=0 for 10 cycles -> out_vld stays 0 and level=3. The 4th write releases the frame next cycle.
- out_rdy=0 and 16 writes (4 frames) -> in_rdy=0 at level=16, frames_avail=4. Assert out_rdy with in_vld held -> in_rdy returns the cycle after the first read. Data stays ordered across pointer wrap.
- Continuous simultaneous traffic at 1/cycle for 64 samples -> level constant, no bubbles after the first frame, 16 frame_done pulses.
- in_fst=1 on the 3rd sample of a frame -> fst_err=1 the next cycle and stays set. Output framing unchanged (out_fst still every 4th sample). clr -> fst_err=0, level=0, out_vld=0.
- Assert reset low asynchronously mid-frame with 6 samples held -> in_rdy=1, out_vld=0, level=0 immediately. A new 4-sample frame after release streams correctly.
